ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter F_CLK, default 48e6: clock frequency in Hz.
REQ-002 Parameter T_RES, default 50e-6: low time in seconds that ends a frame (latch).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port din, input, 1: asynchronous WS2812 serial line in.
REQ-006 Port data, output, 24: last received word, first bit received in bit 23 (MSB first).
REQ-007 Port valid, output, 1: one-cycle pulse when data is updated.
REQ-008 Port latch, output, 1: one-cycle pulse when a frame-ending low period is detected.
REQ-009 Port err, output, 1: one-cycle pulse on a protocol error.
REQ-010 Port dout, output, 1: forwarded serial stream for the next device in the chain.
REQ-011 Port bsy, output, 1: high whenever the state is not IDLE.

Function
REQ-012 Derived constants: N_THR = ceil(525e-9*F_CLK) = 26; N_HMAX = ceil(1.5e-6*F_CLK) = 72; N_RES = ceil(T_RES*F_CLK) = 2400.
REQ-013 Counter width = clog2(N_RES+1); the counter shall saturate, never wrap.
REQ-014 din shall pass through a 2-flop synchronizer giving din_s; all timing is measured on din_s.
REQ-015 States: IDLE, HIGH, LOW, FWD, WAIT.
REQ-016 IDLE: on the din_s 0->1 edge, go to HIGH with cnt = 1 and the bit index cleared to 0.
REQ-017 HIGH: increment cnt each cycle din_s = 1; H = number of cycles din_s is sampled high.
- If cnt exceeds N_HMAX: pulse err and go to WAIT.
REQ-018 HIGH, on din_s falling to 0: shift in bit = (H >= N_THR), then go to LOW with cnt = 1.
- Bit 24 of the word goes to FWD instead of LOW.
REQ-019 On the 24th bit: load data and pulse valid in the first cycle din_s is 0, so data and valid change in the same cycle.
REQ-020 LOW, din_s rises before cnt reaches N_RES: go to HIGH with cnt = 1.
REQ-021 LOW, cnt reaches N_RES: pulse latch and err (partial word), discard the bits, go to IDLE.
- data is not modified.
REQ-022 FWD: dout = din_s; count consecutive low cycles and reset the count on any high sample.
- At N_RES low cycles: pulse latch, set dout = 0, go to IDLE.
REQ-023 dout shall be 0 in every state other than FWD.
- The forwarded stream is delayed by exactly 2 cycles from din, with no pulse-width distortion.
REQ-024 WAIT: ignore din_s until N_RES consecutive low cycles, then pulse latch and go to IDLE.
- No valid is produced in WAIT.
REQ-025 valid, latch and err shall each be high for exactly one cycle per event.
- Simultaneous latch and err in REQ-021 is legal.
REQ-026 A high pulse of 1 cycle is legal and decodes as 0; no glitch filtering beyond the synchronizer.

Reset
REQ-027 On rst = 0, immediately and asynchronously set:
- state = IDLE; data = 0; valid = latch = err = 0; dout = 0; cnt = 0; bit index = 0; synchronizer flops = 0.
REQ-028 Reset asserted mid-word discards the partial word.
- After release, decoding restarts at the next din_s rising edge, with no valid for the aborted word.

Verification (F_CLK = 48e6)
REQ-029 Send 0xA5C3F0 (bit 0 = 17 cycles high / 43 low, bit 1 = 34 high / 26 low) -> one valid pulse, data = 0xA5C3F0, bsy = 1 after the first edge.
REQ-030 After REQ-029, send 0x123456 then hold low for 2400 cycles:
- dout reproduces that waveform delayed 2 cycles.
- data stays 0xA5C3F0.
- one latch pulse follows, then dout = 0 and bsy = 0.
REQ-031 Threshold: a word whose MSB high time is 25 cycles decodes bit 23 = 0; with 26 cycles it decodes bit 23 = 1.
REQ-032 A 73-cycle high pulse at bit 5 -> err pulse, no valid.
- Further pulses are ignored until 2400 low cycles, then latch and return to IDLE.
REQ-033 10 bits sent, then 2400 low cycles -> latch and err in the same cycle, no valid, data unchanged.
REQ-034 rst pulsed low during bit 12 -> outputs clear immediately; a fresh 24-bit word afterwards decodes correctly.

Source files
------------

// File: rtl/ws2812_rx_if.sv
// Signal bundle between a WS2812 line source/consumer and the ws2812_rx decoder.
// The decoder takes the slave view; the line driver / checker takes the master view.
interface ws2812_rx_if;
    logic        din;
    logic [23:0] data;
    logic        valid;
    logic        latch;
    logic        err;
    logic        dout;
    logic        bsy;

    modport master (
        output din,
        input  data,
        input  valid,
        input  latch,
        input  err,
        input  dout,
        input  bsy
    );

    modport slave (
        input  din,
        output data,
        output valid,
        output latch,
        output err,
        output dout,
        output bsy
    );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes the first 24-bit word of a frame and
// forwards the rest of the frame, delayed two cycles, to the next device.
module ws2812_rx #(
    parameter real F_CLK = 48e6,
    parameter real T_RES = 50e-6
) (
    input  logic         clk,
    input  logic         rst,
    ws2812_rx_if.slave   bus,
    output logic [2:0]   dbg_state
);
    // Cycle counts are rounded up; the small epsilon keeps exact products
    // such as 1.5us * 48MHz from rounding up by floating-point noise.
    localparam real X_THR  = 525e-9 * F_CLK;
    localparam real X_HMAX = 1.5e-6 * F_CLK;
    localparam real X_RES  = T_RES * F_CLK;
    localparam int  I_THR  = $rtoi(X_THR);
    localparam int  I_HMAX = $rtoi(X_HMAX);
    localparam int  I_RES  = $rtoi(X_RES);
    localparam int  N_THR  = ($itor(I_THR)  < X_THR  - 1e-6) ? I_THR  + 1 : I_THR;
    localparam int  N_HMAX = ($itor(I_HMAX) < X_HMAX - 1e-6) ? I_HMAX + 1 : I_HMAX;
    localparam int  N_RES  = ($itor(I_RES)  < X_RES  - 1e-6) ? I_RES  + 1 : I_RES;
    localparam int  CW     = $clog2(N_RES + 1);

    localparam logic [CW-1:0] THR_C  = CW'(N_THR);
    localparam logic [CW-1:0] HMAX_C = CW'(N_HMAX);
    localparam logic [CW-1:0] RES_M1 = CW'(N_RES - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HIGH = 3'd1,
        LOW  = 3'd2,
        FWD  = 3'd3,
        WAIT = 3'd4
    } state_t;

    state_t         state, state_n;
    logic           s1, s2, din_q;
    logic           din_s, rise;
    logic [CW-1:0]  cnt, cnt_n, cnt_inc;
    logic [4:0]     idx, idx_n;
    logic [22:0]    sr, sr_n;
    logic [23:0]    data_r, data_n;
    logic           valid_r, valid_n;
    logic           latch_r, latch_n;
    logic           err_r, err_n;
    logic           bit_v;

    assign din_s   = s2;
    assign rise    = din_s & ~din_q;
    assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    assign bit_v   = (cnt >= THR_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            din_q   <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sr      <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            latch_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            s1      <= bus.din;
            s2      <= s1;
            din_q   <= s2;
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            sr      <= sr_n;
            data_r  <= data_n;
            valid_r <= valid_n;
            latch_r <= latch_n;
            err_r   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sr_n    = sr;
        data_n  = data_r;
        valid_n = 1'b0;
        latch_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = HIGH;
                    cnt_n   = ONE_C;
                    idx_n   = '0;
                end
            end
            HIGH: begin
                if (din_s) begin
                    // cnt equals the high samples seen so far; one more is too long
                    if (cnt >= HMAX_C) begin
                        err_n   = 1'b1;
                        state_n = WAIT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else begin
                    cnt_n = ONE_C;
                    if (idx == 5'd23) begin
                        data_n  = {sr, bit_v};
                        valid_n = 1'b1;
                        state_n = FWD;
                    end else begin
                        sr_n    = {sr[21:0], bit_v};
                        idx_n   = idx + 5'd1;
                        state_n = LOW;
                    end
                end
            end
            LOW: begin
                if (din_s) begin
                    state_n = HIGH;
                    cnt_n   = ONE_C;
                end else if (cnt >= RES_M1) begin
                    latch_n = 1'b1;
                    err_n   = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = '0;
                    sr_n    = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            FWD, WAIT: begin
                // Only a full reset gap of consecutive lows ends the frame
                if (din_s) begin
                    cnt_n = '0;
                end else if (cnt >= RES_M1) begin
                    latch_n = 1'b1;
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Combinational forward keeps the repeater latency at the synchronizer depth
    assign bus.dout  = (state == FWD) && din_s;
    assign bus.bsy   = (state != IDLE);
    assign bus.data  = data_r;
    assign bus.valid = valid_r;
    assign bus.latch = latch_r;
    assign bus.err   = err_r;
    assign dbg_state = state;
endmodule

// File: tb/tb_ws2812_rx.sv
// Randomized scoreboard bench for ws2812_rx: frames are described as pulse
// lists, a frame-level model predicts words/latch/err, a monitor checks them.
module tb_ws2812_rx;
    localparam int THR  = 26;
    localparam int HMAX = 72;
    localparam int NRES = 2400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  dbg_state;

    ws2812_rx_if bus();

    ws2812_rx #(.F_CLK(48e6), .T_RES(50e-6)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] exp_q[$];
    logic [1:0]  ev_q[$];
    logic [23:0] cur_data = '0;
    int          ph[$];
    int          pl[$];
    int          dout_mode = 0;
    logic        h1 = 1'b0;
    logic        h2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add_bit(input logic b, input bit fixed);
        if (fixed) begin
            ph.push_back(b ? 34 : 17);
            pl.push_back(b ? 26 : 43);
        end else begin
            ph.push_back(b ? int'($urandom_range(72, 26)) : int'($urandom_range(25, 1)));
            pl.push_back(int'($urandom_range(120, 6)));
        end
    endtask

    task automatic add_word(input logic [23:0] w, input bit fixed);
        for (int i = 23; i >= 0; i--) add_bit(w[i], fixed);
    endtask

    task automatic end_frame();
        pl[pl.size() - 1] = NRES;
    endtask

    // Frame-level prediction: first 24 pulses decode, a too-long pulse aborts,
    // a short frame ends in latch+err, later pulses are only repeated.
    task automatic model_frame(output bit ok);
        logic [23:0] w;
        bit          abort;
        w     = '0;
        abort = 0;
        for (int i = 0; i < 24 && i < ph.size(); i++) begin
            if (!abort) begin
                if (ph[i] > HMAX) begin
                    abort = 1;
                    ev_q.push_back(2'b01);
                end else begin
                    w = {w[22:0], (ph[i] >= THR)};
                end
            end
        end
        ok = 0;
        if (abort) begin
            ev_q.push_back(2'b10);
        end else if (ph.size() < 24) begin
            ev_q.push_back(2'b11);
        end else begin
            ok = 1;
            exp_q.push_back(w);
            cur_data = w;
            ev_q.push_back(2'b10);
        end
    endtask

    task automatic send_frame();
        bit ok;
        model_frame(ok);
        dout_mode = 1;
        for (int i = 0; i < ph.size(); i++) begin
            drive(1'b1, ph[i]);
            if (i == 0) begin
                drive(1'b0, 3);
                check("bsy_after_edge", 32'(bus.bsy), 32'd1);
                drive(1'b0, pl[i] - 3);
            end else if (i == 23 && ok) begin
                dout_mode = 0;
                drive(1'b0, 3);
                dout_mode = 2;
                drive(1'b0, pl[i] - 3);
            end else begin
                drive(1'b0, pl[i]);
            end
        end
        drive(1'b0, 10);
        check("data_after_frame", 32'(bus.data), 32'(cur_data));
        check("bsy_idle", 32'(bus.bsy), 32'd0);
        check("dout_idle", 32'(bus.dout), 32'd0);
        check("words_pending", exp_q.size(), 32'd0);
        check("events_pending", ev_q.size(), 32'd0);
        dout_mode = 1;
        ph.delete();
        pl.delete();
    endtask

    // Monitor: pops expectations on every output event and checks the repeater.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.valid) begin
                if (exp_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
                else check("valid_data", 32'(bus.data), 32'(exp_q.pop_front()));
            end
            if (bus.latch || bus.err) begin
                if (ev_q.size() == 0) check("event_unexpected", {30'd0, bus.latch, bus.err}, 32'd0);
                else check("latch_err", {30'd0, bus.latch, bus.err}, 32'(ev_q.pop_front()));
            end
        end
        if (dout_mode == 1) check("dout_quiet", 32'(bus.dout), 32'd0);
        else if (dout_mode == 2) check("dout_fwd", 32'(bus.dout), 32'(h2));
        h2 = h1;
        h1 = bus.din;
    end

    initial begin
        logic [23:0] w;
        bus.din = 1'b0;
        rst = 1'b0;
        #3;
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_latch", 32'(bus.latch), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_bsy", 32'(bus.bsy), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b0, 10);

        // Known word, then a second word that must only be repeated
        add_word(24'hA5C3F0, 1);
        add_word(24'h123456, 1);
        end_frame();
        send_frame();
        check("data_kept_A5C3F0", 32'(bus.data), 32'hA5C3F0);

        // MSB threshold boundary
        w = 24'($urandom);
        add_word(w, 0);
        ph[0] = 25;
        end_frame();
        send_frame();
        check("thr_25_is_0", 32'(bus.data[23]), 32'd0);
        add_word(w, 0);
        ph[0] = 26;
        end_frame();
        send_frame();
        check("thr_26_is_1", 32'(bus.data[23]), 32'd1);

        // Over-long high at bit 5
        add_word(24'($urandom), 0);
        ph[5] = 73;
        end_frame();
        send_frame();

        // Partial word of 10 bits
        for (int i = 0; i < 10; i++) add_bit(1'($urandom), 0);
        end_frame();
        send_frame();

        // Reset during bit 12
        add_word(24'($urandom), 0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, ph[i]);
            drive(1'b0, pl[i]);
        end
        drive(1'b1, 10);
        rst = 1'b0;
        #1;
        check("midrst_data", 32'(bus.data), 32'd0);
        check("midrst_valid", 32'(bus.valid), 32'd0);
        check("midrst_latch", 32'(bus.latch), 32'd0);
        check("midrst_err", 32'(bus.err), 32'd0);
        check("midrst_dout", 32'(bus.dout), 32'd0);
        check("midrst_bsy", 32'(bus.bsy), 32'd0);
        bus.din = 1'b0;
        cur_data = '0;
        ph.delete();
        pl.delete();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b0, 20);
        check("post_rst_data", 32'(bus.data), 32'd0);
        add_word(24'($urandom), 0);
        end_frame();
        send_frame();

        // Random frames, some with extra repeated pulses
        for (int f = 0; f < 4; f++) begin
            add_word(24'($urandom), 0);
            for (int k = 0; k < int'($urandom_range(20, 0)); k++) begin
                ph.push_back(int'($urandom_range(90, 1)));
                pl.push_back(int'($urandom_range(120, 6)));
            end
            end_frame();
            send_frame();
        end

        check("final_words_left", exp_q.size(), 32'd0);
        check("final_events_left", ev_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
